// File: rtl/reg_file.sv
// RV32 integer register file: x1..x31 storage, x0 hardwired to zero, two combinational
// read ports with same-cycle write-back bypass, one synchronous write port.
module reg_file (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  rs1,
    output logic [31:0] rdata1,
    input  logic [4:0]  rs2,
    output logic [31:0] rdata2,
    input  logic [4:0]  wreg,
    input  logic [31:0] wdata,
    input  logic        wen
);

    // x0 has no storage, so the array starts at index 1.
    logic [31:0] regs_q [1:31];

    // A write that actually lands in storage: not in reset, enabled, not x0.
    logic wr_commit;
    assign wr_commit = reset_n && wen && (wreg != 5'd0);

    // NOTE: the whole array is cleared on reset because the pipeline may read any
    // register before it is first written; without this, reads would return X.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_commit) begin
            regs_q[wreg] <= wdata;
        end
    end

    // Write-first bypass lets write-back data reach decode in the same cycle.
    always_comb begin
        rdata1 = '0;
        if (reset_n && rs1 != 5'd0) begin
            if (wen && wreg == rs1) begin
                rdata1 = wdata;
            end else begin
                rdata1 = regs_q[rs1];
            end
        end
    end

    always_comb begin
        rdata2 = '0;
        if (reset_n && rs2 != 5'd0) begin
            if (wen && wreg == rs2) begin
                rdata2 = wdata;
            end else begin
                rdata2 = regs_q[rs2];
            end
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios followed by randomized traffic,
// all compared against an array-based architectural model.
module tb_reg_file;

    logic        clk;
    logic        reset_n;
    logic [4:0]  rs1;
    logic [31:0] rdata1;
    logic [4:0]  rs2;
    logic [31:0] rdata2;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        wen;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural state: index 0 is kept at zero and never written.
    logic [31:0] model [32];

    reg_file dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rs1     (rs1),
        .rdata1  (rdata1),
        .rs2     (rs2),
        .rdata2  (rdata2),
        .wreg    (wreg),
        .wdata   (wdata),
        .wen     (wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expect_read(input logic [4:0] rs);
        if (!reset_n)              return 32'h0;
        if (rs == 5'd0)            return 32'h0;
        if (wen && wreg == rs)     return wdata;
        return model[rs];
    endfunction

    task automatic set_in(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] wr,
                          input logic [31:0] wd, input logic we, input logic rn);
        rs1     = r1;
        rs2     = r2;
        wreg    = wr;
        wdata   = wd;
        wen     = we;
        reset_n = rn;
    endtask

    // Called from the low phase of the clock; checks both ports against the model.
    task automatic check_ports(input string tag);
        #1;
        check({tag, "_rd1"}, rdata1, expect_read(rs1));
        check({tag, "_rd2"}, rdata2, expect_read(rs2));
    endtask

    // One rising edge, with the model updated by the architectural write/reset rules.
    task automatic tick();
        @(posedge clk);
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (wen && wreg != 5'd0) begin
            model[wreg] = wdata;
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        set_in(5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check_ports("in_reset");
        tick();

        // Reset clears everything: sweep all indices on both ports.
        set_in(5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            rs2 = 5'(31 - i);
            #1;
            check("reset_sweep_rd1", rdata1, 32'h0);
            check("reset_sweep_rd2", rdata2, 32'h0);
        end

        // Write/readback of x5 and x31.
        set_in(5'd0, 5'd0, 5'd5, 32'hDEADBEEF, 1'b1, 1'b1);
        tick();
        set_in(5'd5, 5'd5, 5'd0, 32'h0, 1'b0, 1'b1);
        #1;
        check("x5_rd1", rdata1, 32'hDEADBEEF);
        check("x5_rd2", rdata2, 32'hDEADBEEF);
        set_in(5'd0, 5'd0, 5'd31, 32'h12345678, 1'b1, 1'b1);
        tick();
        set_in(5'd5, 5'd31, 5'd0, 32'h0, 1'b0, 1'b1);
        #1;
        check("x5_kept", rdata1, 32'hDEADBEEF);
        check("x31_rd2", rdata2, 32'h12345678);

        // x0 hardwired, including no bypass in the cycle of the write.
        set_in(5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b1);
        #1;
        check("x0_nobypass_rd1", rdata1, 32'h0);
        check("x0_nobypass_rd2", rdata2, 32'h0);
        tick();
        set_in(5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1);
        #1;
        check("x0_after_write", rdata1, 32'h0);

        // Bypass: x7=1, x8 known, then write x7 while reading x7 and x8.
        set_in(5'd0, 5'd0, 5'd7, 32'h1, 1'b1, 1'b1);
        tick();
        set_in(5'd0, 5'd0, 5'd8, 32'h0BAD_0008, 1'b1, 1'b1);
        tick();
        set_in(5'd7, 5'd8, 5'd7, 32'hA5A5A5A5, 1'b1, 1'b1);
        #1;
        check("bypass_rd1", rdata1, 32'hA5A5A5A5);
        check("bypass_other_rd2", rdata2, 32'h0BAD_0008);
        tick();
        set_in(5'd7, 5'd7, 5'd0, 32'h0, 1'b0, 1'b1);
        #1;
        check("bypass_stored_rd1", rdata1, 32'hA5A5A5A5);
        check("bypass_stored_rd2", rdata2, 32'hA5A5A5A5);

        // wen gating: x3=0x11, then a disabled write must not show anywhere.
        set_in(5'd0, 5'd0, 5'd3, 32'h11, 1'b1, 1'b1);
        tick();
        set_in(5'd3, 5'd3, 5'd3, 32'hCAFEF00D, 1'b0, 1'b1);
        #1;
        check("wen0_before_rd1", rdata1, 32'h11);
        check("wen0_before_rd2", rdata2, 32'h11);
        tick();
        #1;
        check("wen0_after_rd1", rdata1, 32'h11);

        // Reset priority over a simultaneous write, outputs forced to zero in reset.
        set_in(5'd9, 5'd5, 5'd9, 32'h55, 1'b1, 1'b0);
        #1;
        check("rst_prio_during_rd1", rdata1, 32'h0);
        check("rst_prio_during_rd2", rdata2, 32'h0);
        tick();
        set_in(5'd9, 5'd5, 5'd0, 32'h0, 1'b0, 1'b1);
        #1;
        check("rst_prio_after_x9", rdata1, 32'h0);
        check("rst_cleared_x5", rdata2, 32'h0);

        // Randomized traffic against the model, with occasional resets and forced
        // address collisions so the bypass and same-register cases occur often.
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] r1, r2, wr;
            wr = 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
            set_in(r1, r2, wr, $urandom, 1'($urandom_range(0, 2) != 0),
                   1'($urandom_range(0, 63) != 0));
            check_ports("rand");
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
